spi_link: RTL and testbench

//  Self-contained SPI master + SPI slave pair, wired together internally over MOSI/MISO/SCLK/LOAD.
//  A start pulse makes the master exchange one m-bit word with the slave, full duplex, MSB first.

---
 rtl/spi_link.sv | 152 +++++++++++++++
 tb/tb_spi_link.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_link.sv
// ============================================================================
// Module   : spi_link
// Brief    : Internally wired SPI master/slave pair exchanging one M-bit word,
//            full duplex, MSB first, per start request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_link #(
    parameter int M   = 9,
    parameter int DIV = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st,
    input  logic [M-1:0] MTX_DAT,
    input  logic [M-1:0] STX_DAT,
    output logic [M-1:0] MRX_DAT,
    output logic [M-1:0] SRX_DAT,
    output logic         MOSI,
    output logic         MISO,
    output logic         SCLK,
    output logic         LOAD
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (M > 1) ? $clog2(M) : 1;
    localparam int SW = $clog2(M + 1);

    localparam logic [CW-1:0] C_DIV_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] C_BIT_LAST = BW'(M - 1);
    localparam logic [SW-1:0] C_SBITS    = SW'(M);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state;
    logic           st_q;
    logic [CW-1:0]  div_cnt;
    logic [BW-1:0]  bit_cnt;
    logic [M-1:0]   m_tx;
    logic [M-1:0]   m_rx;

    logic           sclk_q;
    logic           load_q;
    logic [M-1:0]   s_tx;
    logic [M-1:0]   s_rx;
    logic [SW-1:0]  s_cnt;

    // Master: one SCLK period per bit, LOW half first, then HIGH half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            st_q    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            m_tx    <= '0;
            m_rx    <= '0;
            SCLK    <= 1'b0;
            LOAD    <= 1'b1;
            MOSI    <= 1'b0;
            MRX_DAT <= '0;
        end else begin
            st_q <= st;
            case (state)
                S_IDLE: begin
                    if (st && !st_q) begin
                        m_tx    <= MTX_DAT;
                        MOSI    <= MTX_DAT[M-1];
                        LOAD    <= 1'b0;
                        SCLK    <= 1'b0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (div_cnt == C_DIV_LAST) begin
                        div_cnt <= '0;
                        SCLK    <= 1'b1;
                        m_rx    <= {m_rx[M-2:0], MISO};
                        state   <= S_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (div_cnt == C_DIV_LAST) begin
                        div_cnt <= '0;
                        SCLK    <= 1'b0;
                        if (bit_cnt == C_BIT_LAST) begin
                            state <= S_DONE;
                        end else begin
                            m_tx    <= {m_tx[M-2:0], 1'b0};
                            MOSI    <= m_tx[M-2];
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= S_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    LOAD    <= 1'b1;
                    MRX_DAT <= m_rx;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Slave: reacts one cycle after each registered SCLK/LOAD edge.
    // s_cnt suppresses the shift on the final falling edge so MISO holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q  <= 1'b0;
            load_q  <= 1'b1;
            s_tx    <= '0;
            s_rx    <= '0;
            s_cnt   <= '0;
            MISO    <= 1'b0;
            SRX_DAT <= '0;
        end else begin
            sclk_q <= SCLK;
            load_q <= LOAD;
            if (!LOAD && load_q) begin
                s_tx  <= STX_DAT;
                MISO  <= STX_DAT[M-1];
                s_cnt <= '0;
            end else if (!LOAD) begin
                if (SCLK && !sclk_q) begin
                    s_rx  <= {s_rx[M-2:0], MOSI};
                    s_cnt <= s_cnt + 1'b1;
                end else if (!SCLK && sclk_q && (s_cnt != C_SBITS)) begin
                    s_tx <= {s_tx[M-2:0], 1'b0};
                    MISO <= s_tx[M-2];
                end
            end
            if (LOAD && !load_q) begin
                SRX_DAT <= s_rx;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_link.sv
// ============================================================================
// Module   : tb_spi_link
// Brief    : Self-checking bench for spi_link: per-cycle frame model plus
//            directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_link;

    localparam int M    = 9;
    localparam int DIV  = 50;
    localparam int FLEN = 2 * M * DIV + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         st;
    logic [M-1:0] mtx;
    logic [M-1:0] stx;
    logic [M-1:0] mrx;
    logic [M-1:0] srx;
    logic         mosi;
    logic         miso;
    logic         sclk;
    logic         load;

    always #5 clk = ~clk;

    spi_link #(.M(M), .DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .st      (st),
        .MTX_DAT (mtx),
        .STX_DAT (stx),
        .MRX_DAT (mrx),
        .SRX_DAT (srx),
        .MOSI    (mosi),
        .MISO    (miso),
        .SCLK    (sclk),
        .LOAD    (load)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: outputs as a function of the cycle index k since start.
    int           k;
    bit           busy, pend, st_prev, start;
    logic [M-1:0] mtx_c, stx_c, e_mrx, e_srx;
    logic         e_mosi, e_miso, e_sclk, e_load;

    function automatic int clampm(input int v);
        return (v > M - 1) ? M - 1 : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 0; pend = 0; st_prev = 0; k = 0;
            e_mrx = '0; e_srx = '0;
            e_mosi = 1'b0; e_miso = 1'b0; e_sclk = 1'b0; e_load = 1'b1;
        end else begin
            start   = st && !st_prev && !busy;
            st_prev = st;
            if (pend) begin
                e_srx = mtx_c;
                pend  = 0;
            end
            if (busy) begin
                k++;
                if (k == FLEN) begin
                    busy   = 0;
                    pend   = 1;
                    e_mrx  = stx_c;
                    e_load = 1'b1;
                    e_sclk = 1'b0;
                    e_miso = stx_c[0];
                end
            end
            if (start) begin
                busy  = 1;
                k     = 0;
                mtx_c = mtx;
                stx_c = stx;
            end
            if (busy) begin
                e_load = 1'b0;
                e_sclk = ((k / DIV) % 2) == 1;
                e_mosi = mtx_c[M-1-clampm(k / (2 * DIV))];
                if (k >= 1) e_miso = stx_c[M-1-clampm((k - 1) / (2 * DIV))];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mrx_cyc",  mrx,  e_mrx);
            chk("srx_cyc",  srx,  e_srx);
            chk("mosi_cyc", mosi, e_mosi);
            chk("miso_cyc", miso, e_miso);
            chk("sclk_cyc", sclk, e_sclk);
            chk("load_cyc", load, e_load);
        end
    end

    // Frame statistics: LOAD-low length and SCLK rising edges.
    int   low_cnt = 0, rises = 0, last_len = 0, last_rises = 0, frames = 0;
    logic p_load = 1'b1, p_sclk = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0; rises = 0; p_load = 1'b1; p_sclk = 1'b0;
        end else begin
            if (!load) low_cnt++;
            if (sclk && !p_sclk) rises++;
            if (load && !p_load) begin
                last_len   = low_cnt;
                last_rises = rises;
                frames++;
                low_cnt = 0;
                rises   = 0;
            end
            p_load = load;
            p_sclk = sclk;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        st = 1'b1;
        cyc(1);
        st = 1'b0;
    endtask

    task automatic wait_frame(input int f0);
        int t = 0;
        while (frames == f0 && t < FLEN + 200) begin
            cyc(1);
            t++;
        end
        chk("frame_timeout", 32'(frames != f0), 32'd1);
        cyc(3);
    endtask

    task automatic check_frame(input string name, input logic [M-1:0] xm, input logic [M-1:0] xs);
        chk({name, "_len"},   last_len,   FLEN);
        chk({name, "_rises"}, last_rises, M);
        chk({name, "_mrx"},   mrx,        xm);
        chk({name, "_srx"},   srx,        xs);
    endtask

    int f0;

    initial begin
        rst = 1'b1; st = 1'b0; mtx = '0; stx = '0;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_load", load, 1'b1);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_miso", miso, 1'b0);
        chk("rst_mrx",  mrx,  9'd0);
        chk("rst_srx",  srx,  9'd0);

        // Basic exchange
        mtx = 9'b101111010; stx = 9'b111011011;
        f0 = frames;
        pulse();
        wait_frame(f0);
        check_frame("t1", 9'b111011011, 9'b101111010);

        // Repeat after a gap; outputs must hold in between
        cyc(300);
        chk("t2_hold_mrx", mrx, 9'b111011011);
        chk("t2_hold_srx", srx, 9'b101111010);
        f0 = frames;
        pulse();
        wait_frame(f0);
        check_frame("t2", 9'b111011011, 9'b101111010);

        // Held start gives exactly one frame
        f0 = frames;
        st = 1'b1;
        cyc(3 * FLEN);
        st = 1'b0;
        chk("t3_frames", frames - f0, 1);
        chk("t3_len", last_len, FLEN);
        cyc(10);

        // Second start mid-frame is ignored
        f0 = frames;
        pulse();
        cyc(300);
        pulse();
        wait_frame(f0);
        check_frame("t4", 9'b111011011, 9'b101111010);
        cyc(FLEN + 100);
        chk("t4_frames", frames - f0, 1);

        // Input changes mid-frame do not affect the frame in flight
        mtx = 9'h0A5; stx = 9'h15A;
        f0 = frames;
        pulse();
        cyc(400);
        mtx = 9'h1FF; stx = 9'h000;
        wait_frame(f0);
        check_frame("t5", 9'h15A, 9'h0A5);

        // Reset mid-frame, then a clean frame
        mtx = 9'h133; stx = 9'h0CC;
        f0 = frames;
        pulse();
        cyc(400);
        rst = 1'b1;
        #1;
        chk("t6_sclk", sclk, 1'b0);
        chk("t6_load", load, 1'b1);
        chk("t6_mosi", mosi, 1'b0);
        chk("t6_miso", miso, 1'b0);
        chk("t6_mrx",  mrx,  9'd0);
        chk("t6_srx",  srx,  9'd0);
        cyc(2);
        rst = 1'b0;
        cyc(5);
        chk("t6_noframe", frames - f0, 0);
        f0 = frames;
        pulse();
        wait_frame(f0);
        check_frame("t6", 9'h0CC, 9'h133);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
